// File: rtl/clk_div_seq.sv
// clk_div_seq: N-channel divided-clock / enable-strobe generator with a
// settle counter that gates `locked`. Divide ratios live in shadow registers
// that are reloaded on reset or on an accepted cfg_load. Every reload realigns
// all channels, then runs a fresh settle period.
//
// Optional feature macro: CLK_DIV_PHASE_EN
//   defined   -> phase_i port and phase shadows exist; each channel counter
//                starts at min(phase, div-1)
//   undefined -> all channel counters start at 0 (rising edges aligned)
//
// state  | meaning
// -------+------------------------------------------------------------
// ALIGN  | one cycle: load channel counters with start values, clear settle
// SETTLE | channels running, settle counter counting up to LOCK_CYCLES-1
// LOCKED | channels running, locked asserted
module clk_div_seq #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
`ifdef CLK_DIV_PHASE_EN
  input  logic [NUM_CH*DIV_W-1:0] phase_i,
`endif
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outen,
  output logic                    locked,
  output logic                    cfg_busy
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               load_acc;
  logic               running;

  logic [DIV_W-1:0]   div_q   [NUM_CH];
  logic [DIV_W-1:0]   cnt_q   [NUM_CH];
  logic [DIV_W-1:0]   cnt_d   [NUM_CH];
  logic [DIV_W-1:0]   last_w  [NUM_CH];
  logic [DIV_W-1:0]   start_w [NUM_CH];
  logic [NUM_CH-1:0]  outclk_d;
  logic [NUM_CH-1:0]  outen_d;

`ifdef CLK_DIV_PHASE_EN
  logic [DIV_W-1:0]   phase_q [NUM_CH];
`endif

  // A reload request only counts while the channels are running.
  assign load_acc = cfg_load && (state_q != ALIGN);

  // Next state and settle counter.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ALIGN: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (load_acc) begin
          state_d = ALIGN;
        end else if (settle_q == SET_LAST) begin
          state_d = LOCKED;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      LOCKED: begin
        if (load_acc) begin
          state_d = ALIGN;
        end
      end
      default: state_d = ALIGN;
    endcase
  end

  // Outputs are forced low in ALIGN and on the edge that enters ALIGN.
  assign running = (state_q != ALIGN) && (state_d != ALIGN);

  // Per-channel counter next value and output decode; div 0 behaves as 1.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      last_w[k] = (div_q[k] == '0) ? '0 : div_q[k] - DIV_W'(1);
`ifdef CLK_DIV_PHASE_EN
      start_w[k] = (phase_q[k] > last_w[k]) ? last_w[k] : phase_q[k];
`else
      start_w[k] = '0;
`endif
      cnt_d[k] = cnt_q[k];
      if (state_q == ALIGN) begin
        cnt_d[k] = start_w[k];
      end else if (cnt_q[k] >= last_w[k]) begin
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + DIV_W'(1);
      end
      outclk_d[k] = running && (div_q[k] > DIV_W'(1)) && (cnt_q[k] < (div_q[k] >> 1));
      outen_d[k]  = running && ((div_q[k] <= DIV_W'(1)) || (cnt_q[k] == last_w[k]));
    end
  end

  // State, settle counter, channel counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= ALIGN;
      settle_q <= '0;
      outclk   <= '0;
      outen    <= '0;
      locked   <= 1'b0;
      cfg_busy <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      outclk   <= outclk_d;
      outen    <= outen_d;
      locked   <= (state_d == LOCKED);
      cfg_busy <= (state_d != LOCKED);
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Shadow configuration: follows the inputs during reset and on accepted loads.
  always_ff @(posedge refclk) begin
    if (rst || load_acc) begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k] <= div_i[k*DIV_W +: DIV_W];
`ifdef CLK_DIV_PHASE_EN
        phase_q[k] <= phase_i[k*DIV_W +: DIV_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_div_seq.sv
// Directed bench for clk_div_seq (NUM_CH=2, DIV_W=8, LOCK_CYCLES=16).
module tb_clk_div_seq;

  logic        refclk = 1'b0;
  logic        rst;
  logic [15:0] div_i;
  logic [15:0] phase_i;
  logic        cfg_load;
  logic [1:0]  outclk;
  logic [1:0]  outen;
  logic        locked;
  logic        cfg_busy;

  int total = 0;
  int bad   = 0;

  clk_div_seq #(.NUM_CH(2), .DIV_W(8), .LOCK_CYCLES(16)) dut (
    .refclk   (refclk),
    .rst      (rst),
    .div_i    (div_i),
`ifdef CLK_DIV_PHASE_EN
    .phase_i  (phase_i),
`endif
    .cfg_load (cfg_load),
    .outclk   (outclk),
    .outen    (outen),
    .locked   (locked),
    .cfg_busy (cfg_busy)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {outclk, outen, locked, cfg_busy};
  endfunction

  // Called just after the ALIGN->SETTLE edge (E1). Checks E1 and edges 2..n.
  // Channel k with ratio d and start s shows counter value (i+s) mod d at
  // decode index i = e-2; locked appears from edge 17 on.
  task automatic check_run(input int d0, input int d1, input int s0, input int s1,
                           input int n, input string name);
    int d [2];
    int s [2];
    logic [1:0] ec, ee;
    logic lk;
    d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
    chk($sformatf("%s e1", name), obs(), 6'b000001);
    for (int e = 2; e <= n; e++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        int de, c;
        de = (d[k] < 2) ? 1 : d[k];
        c  = ((e - 2) + s[k]) % de;
        ec[k] = (d[k] >= 2) && (c < d[k] / 2);
        ee[k] = (d[k] < 2) || (c == de - 1);
      end
      lk = (e >= 17);
      chk($sformatf("%s e%0d", name, e), obs(), {ec, ee, lk, ~lk});
    end
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; div_i = {8'd2, 8'd4}; phase_i = '0;
    tick(); tick();
    chk("reset", obs(), 6'b000001);

    // Reset release, div={4,2}
    rst = 1'b0;
    tick();
    check_run(4, 2, 0, 0, 24, "div42");

    // Reload while LOCKED with div={3,0}
    div_i = {8'd0, 8'd3}; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load30 drop", obs(), 6'b000001);
    tick();
    check_run(3, 0, 0, 0, 20, "div30");

    // Reload while LOCKED with div={8,8}
    div_i = {8'd8, 8'd8}; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load88 drop", obs(), 6'b000001);
    tick();
    check_run(8, 8, 0, 0, 20, "div88");

    // Two consecutive loads: second (in ALIGN) must be ignored
    div_i = {8'd2, 8'd4}; cfg_load = 1'b1;
    tick();
    chk("dbl drop", obs(), 6'b000001);
    div_i = {8'd3, 8'd3};
    tick();
    cfg_load = 1'b0;
    check_run(4, 2, 0, 0, 12, "dbl");

    // rst together with cfg_load mid-SETTLE, then clean restart
    rst = 1'b1; cfg_load = 1'b1; div_i = {8'd2, 8'd4};
    tick();
    chk("rstload", obs(), 6'b000001);
    rst = 1'b0; cfg_load = 1'b0;
    tick();
    check_run(4, 2, 0, 0, 20, "rstrel");

`ifdef CLK_DIV_PHASE_EN
    rst = 1'b1; div_i = {8'd4, 8'd4}; phase_i = {8'd2, 8'd0};
    tick();
    rst = 1'b0;
    tick();
    check_run(4, 4, 0, 2, 12, "ph02");
    phase_i = {8'd9, 8'd0}; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("ph9 drop", obs(), 6'b000001);
    tick();
    check_run(4, 4, 0, 3, 12, "ph09");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
